// File: rtl/mrd_dft_rdx5_cfg.sv
// Radix-5 Winograd DFT butterfly: three-stage pipeline with a single global enable,
// forward/inverse mode tag, output rounding/saturation and a sticky saturation flag.
module mrd_dft_rdx5_cfg #(
   parameter int wDataInOut = 30,
   parameter int wCoef      = 18,
   parameter int SCALE      = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_val,
   output logic                         in_rdy,
   input  logic                         in_inv,
   input  logic signed [wDataInOut-1:0] din_real [5],
   input  logic signed [wDataInOut-1:0] din_imag [5],
   output logic                         out_val,
   input  logic                         out_rdy,
   output logic                         out_inv,
   output logic signed [wDataInOut-1:0] dout_real [5],
   output logic signed [wDataInOut-1:0] dout_imag [5],
   output logic                         sat_flag,
   input  logic                         sat_clr
);

   localparam int W    = wDataInOut;
   localparam int WI   = W + 4;
   localparam int FRAC = wCoef - 4;
   localparam int WP   = WI + wCoef;

   typedef logic signed [WI-1:0] wide_t;
   typedef logic signed [wCoef-1:0] coef_t;

   localparam coef_t K1 = wCoef'($rtoi(0.559017 * (2.0 ** FRAC) + 0.5));
   localparam coef_t K2 = wCoef'($rtoi(1.538842 * (2.0 ** FRAC) + 0.5));
   localparam coef_t K3 = wCoef'($rtoi(0.363271 * (2.0 ** FRAC) + 0.5));
   localparam coef_t K4 = wCoef'($rtoi(0.951057 * (2.0 ** FRAC) + 0.5));

   localparam int    RND_SH  = (SCALE > 0) ? SCALE - 1 : 0;
   localparam wide_t RND_ADD = (SCALE > 0) ? (wide_t'(1) <<< RND_SH) : '0;
   localparam wide_t MAXV    = (wide_t'(1) <<< (W - 1)) - wide_t'(1);
   localparam wide_t MINV    = -(wide_t'(1) <<< (W - 1));

   function automatic wide_t neg_if(input wide_t v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic wide_t cmul(input wide_t v, input coef_t k);
      logic signed [WP-1:0] p;
      p = WP'(v) * WP'(k);
      return wide_t'(p >>> FRAC);
   endfunction

   // {overflow, value}: round half up, shift by SCALE, clamp to the output range
   function automatic logic [W:0] rnd_sat(input wide_t v);
      wide_t r;
      r = (v + RND_ADD) >>> SCALE;
      if (r > MAXV) return {1'b1, MAXV[W-1:0]};
      if (r < MINV) return {1'b1, MINV[W-1:0]};
      return {1'b0, r[W-1:0]};
   endfunction

   logic en;
   logic vld_p1_q, vld_p2_q, out_val_q;
   logic inv_p1_q, inv_p2_q, out_inv_q;
   logic sat_q, sat_set;

   // index [0] = real, [1] = imaginary
   wide_t x0_p1_d [2], s_p1_d [2], t_p1_d [2], c_p1_d [2], d_p1_d [2], u_p1_d [2];
   wide_t x0_p1_q [2], s_p1_q [2], t_p1_q [2], c_p1_q [2], d_p1_q [2], u_p1_q [2];
   wide_t y0_p2_d [2], m_p2_d [2], p3_p2_d [2], p4_p2_d [2], p5_p2_d [2], p6_p2_d [2];
   wide_t y0_p2_q [2], m_p2_q [2], p3_p2_q [2], p4_p2_q [2], p5_p2_q [2], p6_p2_q [2];
   logic signed [W-1:0] dout_re_d [5], dout_im_d [5];
   logic signed [W-1:0] dout_re_q [5], dout_im_q [5];
   logic any_ovf;

   assign en     = !out_val_q || out_rdy;
   assign in_rdy = en;

   // Stage 1: input sums and differences
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         wide_t x1, x2, x3, x4;
         x1 = (k == 0) ? wide_t'(din_real[1]) : wide_t'(din_imag[1]);
         x2 = (k == 0) ? wide_t'(din_real[2]) : wide_t'(din_imag[2]);
         x3 = (k == 0) ? wide_t'(din_real[3]) : wide_t'(din_imag[3]);
         x4 = (k == 0) ? wide_t'(din_real[4]) : wide_t'(din_imag[4]);
         x0_p1_d[k] = (k == 0) ? wide_t'(din_real[0]) : wide_t'(din_imag[0]);
         s_p1_d[k]  = (x1 + x4) + (x2 + x3);
         t_p1_d[k]  = (x1 + x4) - (x2 + x3);
         c_p1_d[k]  = x1 - x4;
         d_p1_d[k]  = x2 - x3;
         u_p1_d[k]  = (x1 - x4) + (x2 - x3);
      end
   end

   // Stage 2: DC term, cosine path and cross-coupled sine products
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         y0_p2_d[k] = x0_p1_q[k] + s_p1_q[k];
         m_p2_d[k]  = x0_p1_q[k] - (s_p1_q[k] >>> 2);
         p3_p2_d[k] = cmul(t_p1_q[k], K1);
      end
      p4_p2_d[0] = cmul(neg_if(c_p1_q[1],  inv_p1_q), K2);
      p4_p2_d[1] = cmul(neg_if(c_p1_q[0], !inv_p1_q), K2);
      p5_p2_d[0] = cmul(neg_if(d_p1_q[1],  inv_p1_q), K3);
      p5_p2_d[1] = cmul(neg_if(d_p1_q[0], !inv_p1_q), K3);
      p6_p2_d[0] = cmul(neg_if(u_p1_q[1], !inv_p1_q), K4);
      p6_p2_d[1] = cmul(neg_if(u_p1_q[0],  inv_p1_q), K4);
   end

   // Stage 3: output recombination, scaling and saturation
   always_comb begin
      logic [W:0] rs [2][5];
      any_ovf = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wide_t e, f, g, h;
         e = m_p2_q[k] + p3_p2_q[k];
         g = m_p2_q[k] - p3_p2_q[k];
         f = p5_p2_q[k] + p6_p2_q[k];
         h = p4_p2_q[k] + p6_p2_q[k];
         rs[k][0] = rnd_sat(y0_p2_q[k]);
         rs[k][1] = rnd_sat(e - f);
         rs[k][2] = rnd_sat(g + h);
         rs[k][3] = rnd_sat(g - h);
         rs[k][4] = rnd_sat(e + f);
         for (int j = 0; j < 5; j++) any_ovf = any_ovf | rs[k][j][W];
      end
      for (int j = 0; j < 5; j++) begin
         dout_re_d[j] = rs[0][j][W-1:0];
         dout_im_d[j] = rs[1][j][W-1:0];
      end
   end

   assign sat_set = en && vld_p2_q && any_ovf;

   always_ff @(posedge clk) begin
      if (en) begin
         x0_p1_q <= x0_p1_d;
         s_p1_q  <= s_p1_d;
         t_p1_q  <= t_p1_d;
         c_p1_q  <= c_p1_d;
         d_p1_q  <= d_p1_d;
         u_p1_q  <= u_p1_d;
         y0_p2_q <= y0_p2_d;
         m_p2_q  <= m_p2_d;
         p3_p2_q <= p3_p2_d;
         p4_p2_q <= p4_p2_d;
         p5_p2_q <= p5_p2_d;
         p6_p2_q <= p6_p2_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         out_val_q <= 1'b0;
         inv_p1_q  <= 1'b0;
         inv_p2_q  <= 1'b0;
         out_inv_q <= 1'b0;
         sat_q     <= 1'b0;
         for (int j = 0; j < 5; j++) begin
            dout_re_q[j] <= '0;
            dout_im_q[j] <= '0;
         end
      end else begin
         if (en) begin
            vld_p1_q  <= in_val;
            inv_p1_q  <= in_inv;
            vld_p2_q  <= vld_p1_q;
            inv_p2_q  <= inv_p1_q;
            out_val_q <= vld_p2_q;
            if (vld_p2_q) begin
               out_inv_q <= inv_p2_q;
               dout_re_q <= dout_re_d;
               dout_im_q <= dout_im_d;
            end
         end
         if (sat_set)      sat_q <= 1'b1;
         else if (sat_clr) sat_q <= 1'b0;
      end
   end

   assign out_val   = out_val_q;
   assign out_inv   = out_inv_q;
   assign dout_real = dout_re_q;
   assign dout_imag = dout_im_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_mrd_dft_rdx5_cfg.sv
// Scoreboard bench for mrd_dft_rdx5_cfg: expectations come from a floating-point 5-point DFT
// computed when each vector is accepted; a second 16-bit instance exercises saturation.
module tb_mrd_dft_rdx5_cfg;

   localparam int W  = 30;
   localparam int WB = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n, in_val, in_rdy, in_inv, out_val, out_rdy, out_inv, sat_flag, sat_clr;
   logic signed [W-1:0] din_real [5], din_imag [5], dout_real [5], dout_imag [5];

   logic                 b_rst_n, b_in_val, b_in_rdy, b_in_inv, b_out_val, b_out_rdy, b_out_inv;
   logic                 b_sat_flag, b_sat_clr;
   logic signed [WB-1:0] b_din_real [5], b_din_imag [5], b_dout_real [5], b_dout_imag [5];

   mrd_dft_rdx5_cfg #(.wDataInOut(W), .wCoef(18), .SCALE(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy), .in_inv(in_inv),
      .din_real(din_real), .din_imag(din_imag), .out_val(out_val), .out_rdy(out_rdy),
      .out_inv(out_inv), .dout_real(dout_real), .dout_imag(dout_imag),
      .sat_flag(sat_flag), .sat_clr(sat_clr));

   mrd_dft_rdx5_cfg #(.wDataInOut(WB), .wCoef(18), .SCALE(0)) u_dut16 (
      .clk(clk), .rst_n(b_rst_n), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_inv(b_in_inv),
      .din_real(b_din_real), .din_imag(b_din_imag), .out_val(b_out_val), .out_rdy(b_out_rdy),
      .out_inv(b_out_inv), .dout_real(b_dout_real), .dout_imag(b_dout_imag),
      .sat_flag(b_sat_flag), .sat_clr(b_sat_clr));

   typedef struct packed {
      logic [4:0][31:0] re;
      logic [4:0][31:0] im;
      logic             inv;
      logic             lat;
      logic [7:0]       tol;
      logic [31:0]      acc;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   vr [5];
   int   vi [5];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint obs, input longint exp, input int tol = 0);
      n_chk++;
      if ((obs - exp > tol) || (exp - obs > tol)) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   function automatic longint qsat(input real v, input int w);
      longint q, mx;
      q  = longint'($floor(v + 0.5));
      mx = (longint'(1) <<< (w - 1)) - 1;
      if (q > mx) return mx;
      if (q < -mx - 1) return -mx - 1;
      return q;
   endfunction

   // Exact DFT of vr/vi: X[k] = sum x[n] e^{-+j 2 pi k n / 5}
   function automatic exp_t model(input bit inv, input int tol, input bit lat);
      exp_t e;
      real  sr, si, th, sg;
      e  = '0;
      sg = inv ? -1.0 : 1.0;
      for (int k = 0; k < 5; k++) begin
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < 5; n++) begin
            th = 2.0 * 3.14159265358979 * k * n / 5.0;
            sr = sr + vr[n] * $cos(th) + sg * vi[n] * $sin(th);
            si = si + vi[n] * $cos(th) - sg * vr[n] * $sin(th);
         end
         e.re[k] = 32'(qsat(sr, W));
         e.im[k] = 32'(qsat(si, W));
      end
      e.inv = inv;
      e.tol = 8'(tol);
      e.lat = lat;
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input bit inv, input int tol, input bit lat);
      exp_t e;
      bit   acc;
      int   guard;
      e = model(inv, tol, lat);
      for (int n = 0; n < 5; n++) begin
         din_real[n] = W'(vr[n]);
         din_imag[n] = W'(vi[n]);
      end
      in_inv = inv;
      in_val = 1'b1;
      guard  = 0;
      acc    = 1'b0;
      do begin
         @(negedge clk);
         acc = in_rdy;
         @(posedge clk);
         #1;
         guard++;
      end while (!acc && guard < 200);
      in_val = 1'b0;
      if (!acc) check("accept_timeout", 0, 1);
      else begin
         e.acc = 32'(cyc);
         sb.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int g = 0;
      while (sb.size() > 0 && g < 100) begin
         @(posedge clk);
         g++;
      end
      #1;
      if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int r0, input int i0, input int r1, input int i1);
      for (int n = 0; n < 5; n++) begin
         vr[n] = 0;
         vi[n] = 0;
      end
      vr[0] = r0; vi[0] = i0; vr[1] = r1; vi[1] = i1;
   endtask

   bit                  stall_prev = 1'b0;
   logic signed [W-1:0] hold_re [5], hold_im [5];

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) stall_prev = 1'b0;
      else begin
         if (stall_prev && out_val)
            for (int k = 0; k < 5; k++) begin
               check($sformatf("stall_hold_X%0d_re", k), dout_real[k], hold_re[k]);
               check($sformatf("stall_hold_X%0d_im", k), dout_imag[k], hold_im[k]);
            end
         if (out_val && !out_rdy) begin
            check("in_rdy_stall", in_rdy, 0);
            hold_re    = dout_real;
            hold_im    = dout_imag;
            stall_prev = 1'b1;
         end else stall_prev = 1'b0;
         if (out_val && out_rdy) begin
            if (sb.size() == 0) check("spurious_out", 1, 0);
            else begin
               e = sb.pop_front();
               for (int k = 0; k < 5; k++) begin
                  check($sformatf("X%0d_re", k), dout_real[k], $signed(e.re[k]), int'(e.tol));
                  check($sformatf("X%0d_im", k), dout_imag[k], $signed(e.im[k]), int'(e.tol));
               end
               check("out_inv", out_inv, e.inv);
               if (e.lat) check("latency", cyc - int'(e.acc) + 1, 3);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst_n = 1'b0; in_val = 1'b0; in_inv = 1'b0; out_rdy = 1'b1; sat_clr = 1'b0;
      b_rst_n = 1'b0; b_in_val = 1'b0; b_in_inv = 1'b0; b_out_rdy = 1'b1; b_sat_clr = 1'b0;
      for (int n = 0; n < 5; n++) begin
         din_real[n] = '0; din_imag[n] = '0; b_din_real[n] = '0; b_din_imag[n] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_val", out_val, 0);
      check("rst_in_rdy", in_rdy, 1);
      check("rst_out_inv", out_inv, 0);
      check("rst_sat_flag", sat_flag, 0);
      check("rst_dout_re0", dout_real[0], 0);
      check("rst_dout_im4", dout_imag[4], 0);
      check("rst_b_sat_flag", b_sat_flag, 0);
      rst_n = 1'b1; b_rst_n = 1'b1;
      @(posedge clk);
      #1;

      // DC, with latency measured
      for (int n = 0; n < 5; n++) begin vr[n] = 1000; vi[n] = 0; end
      send(1'b0, 0, 1'b1);
      wait_drain();

      // impulse at x0
      set_vec(100, 0, 0, 0);
      send(1'b0, 0, 1'b0);
      // impulse at x1, forward then inverse
      set_vec(0, 0, 1000, 0);
      send(1'b0, 2, 1'b0);
      send(1'b1, 2, 1'b0);
      set_vec(0, 0, 0, -800);
      send(1'b1, 2, 1'b0);
      wait_drain();

      // backpressure: four back-to-back vectors while downstream stalls for 5 clk
      out_rdy = 1'b0;
      fork
         for (int v = 1; v <= 4; v++) begin
            set_vec(100 * v + 7, -30 * v, 0, 0);
            send(bit'(v % 2), 0, 1'b0);
         end
         begin
            seen = 1'b0;
            for (int g = 0; g < 20 && !seen; g++) begin
               @(negedge clk);
               seen = out_val;
            end
            if (!seen) check("bp_out_val_timeout", 0, 1);
            repeat (5) @(posedge clk);
            #1;
            out_rdy = 1'b1;
         end
      join
      wait_drain();

      // reset with two vectors in flight, one of them parked at the output
      out_rdy = 1'b0;
      set_vec(55, 11, 0, 0);
      send(1'b0, 0, 1'b0);
      set_vec(66, 22, 0, 0);
      send(1'b0, 0, 1'b0);
      @(posedge clk);
      #1;
      check("pre_reset_out_val", out_val, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_val", out_val, 0);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("mid_rst_dout_re%0d", k), dout_real[k], 0);
         check($sformatf("mid_rst_dout_im%0d", k), dout_imag[k], 0);
      end
      sb.delete();
      out_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      set_vec(-321, 123, 0, 0);
      send(1'b0, 0, 1'b1);
      wait_drain();
      check("sat_flag_main", sat_flag, 0);

      // saturation on the 16-bit instance
      for (int n = 0; n < 5; n++) begin
         b_din_real[n] = 16'sd32767;
         b_din_imag[n] = 16'sd32767;
      end
      b_in_val = 1'b1;
      @(negedge clk);
      check("b_in_rdy", b_in_rdy, 1);
      @(posedge clk);
      #1;
      b_in_val = 1'b0;
      seen = 1'b0;
      for (int g = 0; g < 10 && !seen; g++) begin
         @(negedge clk);
         seen = b_out_val;
      end
      if (!seen) check("b_out_val_timeout", 0, 1);
      else begin
         check("b_X0_re", b_dout_real[0], 32767);
         check("b_X0_im", b_dout_imag[0], 32767);
         for (int k = 1; k < 5; k++) begin
            check($sformatf("b_X%0d_re", k), b_dout_real[k], 0);
            check($sformatf("b_X%0d_im", k), b_dout_imag[k], 0);
         end
         check("b_sat_flag_set", b_sat_flag, 1);
      end
      @(posedge clk);
      #1;
      b_sat_clr = 1'b1;
      @(posedge clk);
      #1;
      b_sat_clr = 1'b0;
      check("b_sat_flag_clr", b_sat_flag, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
